// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings and types for the multi-cycle hazard unit.
package hazard_pkg;

  // Forward-select encodings driven on ForwardE for each source operand.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // writeback-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // memory-stage result

  // R15 is the PC. Its reads come from the PC path, so it is never forwarded
  // and a load targeting it never creates a load-use stall.
  localparam logic [3:0] R15 = 4'hF;

  // States of the multi-cycle execute FSM.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Bundle of pipeline-facing signals between the datapath/controller and the
// hazard unit. The master side is the pipeline; the slave side is the unit.
interface hazard_unit_mc_if #(
  parameter int REG_W = 4,
  parameter int NSRC  = 3
);

  // Register addresses and write enables observed in each stage
  logic [NSRC*REG_W-1:0] RAD;
  logic [NSRC*REG_W-1:0] RAE;
  logic [REG_W-1:0]      WA3E;
  logic [REG_W-1:0]      WA3M;
  logic [REG_W-1:0]      WA3W;
  logic                  RegWriteE;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  MemtoRegE;
  logic                  MultiCycE;
  logic                  PCSrcD;
  logic                  PCSrcE;
  logic                  PCSrcM;
  logic                  PCSrcW;
  logic                  BranchTakenD;

  // Control returned to the pipeline
  logic [NSRC*2-1:0]     ForwardE;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushM;
  logic                  MultiBusyE;
  logic                  PCWrPendingF;

  modport master (
    output RAD, RAE, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MultiCycE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenD,
    input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  MultiBusyE, PCWrPendingF
  );

  modport slave (
    input  RAD, RAE, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MultiCycE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenD,
    output ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output MultiBusyE, PCWrPendingF
  );

endinterface

// File: rtl/hazard_unit_mc_multicyc_fsm.sv
// Holds a multi-cycle op in Execute for MUL_CYCLES cycles. The first stall
// cycle is raised combinationally from IDLE. BUSY then covers the remaining
// MUL_CYCLES-1 cycles, and the last of those releases the stall.
module multicyc_fsm #(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic MultiCycE,
  output logic MultiStall,
  output logic MultiBusyE
);
  import hazard_pkg::*;

  // With MUL_CYCLES == 1 the trigger folds to 0, so the FSM stays in IDLE.
  localparam bit MULTI_EN = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : '0;

  mc_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             trig;

  assign trig = MultiCycE && MULTI_EN;

  // State and countdown. MultiCycE is only looked at in IDLE, so a held
  // request cannot retrigger the FSM while it is busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trig) begin
            state_reg <= BUSY;
            cnt_reg   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign MultiStall = ((state_reg == IDLE) && trig) ||
                      ((state_reg == BUSY) && (cnt_reg != '0));
  assign MultiBusyE = (state_reg == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core: per-operand forwarding, load-use stall,
// PC-write flushes and a multi-cycle execute hold. Everything except the
// multi-cycle FSM is combinational.
module hazard_unit_mc #(
  parameter int REG_W      = 4,
  parameter int NSRC       = 3,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_mc_if.slave  hz
);
  import hazard_pkg::*;

  localparam logic [REG_W-1:0] PC_REG = REG_W'(R15);

  logic [NSRC-1:0][1:0] fwd_sel;
  logic [NSRC-1:0]      ld_hit;
  logic                 ld_stall;
  logic                 multi_stall;
  logic                 pc_pend;

  // One forward comparator and one load-use comparator per source operand.
  // M is checked before W, so the youngest producer wins.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [REG_W-1:0] rae_i;
    logic [REG_W-1:0] rad_i;

    assign rae_i = hz.RAE[gi*REG_W +: REG_W];
    assign rad_i = hz.RAD[gi*REG_W +: REG_W];

    assign fwd_sel[gi] = (rae_i == PC_REG)                       ? FWD_RF :
                         (hz.RegWriteM && (hz.WA3M == rae_i))    ? FWD_M  :
                         (hz.RegWriteW && (hz.WA3W == rae_i))    ? FWD_W  :
                                                                   FWD_RF;
    assign ld_hit[gi]  = (rad_i == hz.WA3E);

    // Reset forces every select back to the register file.
    assign hz.ForwardE[gi*2 +: 2] = reset ? FWD_RF : fwd_sel[gi];
  end

  assign ld_stall = hz.MemtoRegE && hz.RegWriteE && (|ld_hit) &&
                    (hz.WA3E != PC_REG);
  assign pc_pend  = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;

  multicyc_fsm #(
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .MultiCycE  (hz.MultiCycE),
    .MultiStall (multi_stall),
    .MultiBusyE (hz.MultiBusyE)
  );

  // MultiStall dominates. A load-use hazard seen while E is held comes back
  // once E is released, because the load-use inputs are still present then.
  // Reset silences every stall and flush.
  assign hz.StallE       = !reset && multi_stall;
  assign hz.StallD       = !reset && (ld_stall || multi_stall);
  assign hz.StallF       = !reset && (ld_stall || multi_stall || pc_pend);
  assign hz.FlushM       = !reset && multi_stall;
  assign hz.FlushE       = !reset && (ld_stall || hz.BranchTakenD) && !multi_stall;
  assign hz.FlushD       = !reset && (pc_pend || hz.PCSrcW || hz.BranchTakenD);
  assign hz.PCWrPendingF = pc_pend;

endmodule
